key_entry_conditioner: RTL and testbench

- Front-end stage that feeds the combination-lock FSM. It conditions the raw board inputs into the clean signals that FSM consumes.
- Synchronizes and debounces two active-low pushbuttons (validate, modify) and emits one single-cycle pulse per physical press.
- Synchronizes the 4 code switches and presents a digit snapshot that is aligned with each pulse, so the lock compares a stable code on the exact pulse cycle.

---
 rtl/key_entry_conditioner.sv | 213 +++++++++++++++++++++
 tb/tb_key_entry_conditioner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_conditioner.sv
// ---------------------------------------------------------------------------
// key_entry_conditioner
//
// Front end for the combination-lock FSM. Turns the raw, bouncy, active-low
// pushbuttons and the asynchronous code switches into clean, single-cycle
// pulses plus a code snapshot that is valid on exactly the pulse cycle.
//
// Ports:
//   CLOCK_50        in   system clock, all state on the rising edge
//   Resetn          in   asynchronous active-low reset
//   KEY_validate_n  in   raw validate button (active-low, bouncy)
//   KEY_modify_n    in   raw modify button (active-low, bouncy)
//   SW[3:0]         in   raw code switches {d3,d2,d1,d0}
//   d_out[3:0]      out  code snapshot, loaded on each pulse, held otherwise
//   validate_pulse  out  one-cycle pulse per accepted validate press
//   modify_pulse    out  one-cycle pulse per accepted modify press
//   busy            out  high while either button FSM is not RELEASED
// ---------------------------------------------------------------------------

package kec_pkg;
   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_e;
endpackage

// ---------------------------------------------------------------------------
// kec_button_fsm
//
// Debounce FSM for one synchronized button.
//
// Ports:
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset
//   pressed_i   in   synchronized button level, 1 = pressed
//   suppress_i  in   drop the pulse of an acceptance on this cycle
//   accept_o    out  combinational: this edge moves PRESS_WAIT -> PRESSED
//   pulse_o     out  registered one-cycle pulse per accepted press
//   state_o     out  current FSM state (debug / checker visibility)
// ---------------------------------------------------------------------------
module kec_button_fsm #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                pressed_i,
   input  logic                suppress_i,
   output logic                accept_o,
   output logic                pulse_o,
   output kec_pkg::btn_state_e state_o
);
   import kec_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   btn_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pulse_q;

   // The counter only advances while it is below CNT_LAST, so it saturates
   // there and never wraps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         case (state_q)
            ST_RELEASED: begin
               if (pressed_i) begin
                  state_q <= ST_PRESS_WAIT;
                  cnt_q   <= '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!pressed_i) begin
                  // Press bounce: give up without a pulse.
                  state_q <= ST_RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
                  pulse_q <= !suppress_i;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!pressed_i) begin
                  state_q <= ST_RELEASE_WAIT;
                  cnt_q   <= '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (pressed_i) begin
                  // Release bounce: back to held, no new pulse.
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= ST_RELEASED;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_RELEASED;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign accept_o = (state_q == ST_PRESS_WAIT) && pressed_i && (cnt_q == CNT_LAST);
   assign pulse_o  = pulse_q;
   assign state_o  = state_q;

endmodule

module key_entry_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       KEY_validate_n,
   input  logic       KEY_modify_n,
   input  logic [3:0] SW,
   output logic [3:0] d_out,
   output logic       validate_pulse,
   output logic       modify_pulse,
   output logic       busy
);
   import kec_pkg::*;

   // Two-flop synchronizers. Buttons reset to 1 (released) so a key held
   // through reset is seen as a fresh press once reset is removed.
   logic [1:0] kv_sync_q;
   logic [1:0] km_sync_q;
   logic [3:0] sw_meta_q;
   logic [3:0] sw_s_q;
   logic [3:0] d_out_q;

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         kv_sync_q <= 2'b11;
         km_sync_q <= 2'b11;
         sw_meta_q <= 4'b0000;
         sw_s_q    <= 4'b0000;
      end else begin
         kv_sync_q <= {kv_sync_q[0], KEY_validate_n};
         km_sync_q <= {km_sync_q[0], KEY_modify_n};
         sw_meta_q <= SW;
         sw_s_q    <= sw_meta_q;
      end
   end

   logic       v_accept;
   logic       m_accept;
   logic       v_pulse;
   logic       m_pulse;
   btn_state_e v_state;
   btn_state_e m_state;

   kec_button_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_validate_fsm (
      .clk_i      (CLOCK_50),
      .rst_ni     (Resetn),
      .pressed_i  (!kv_sync_q[1]),
      .suppress_i (1'b0),
      .accept_o   (v_accept),
      .pulse_o    (v_pulse),
      .state_o    (v_state)
   );

   // On a simultaneous acceptance validate wins; the modify FSM still moves
   // to PRESSED so it cannot pulse later for the same press.
   kec_button_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_modify_fsm (
      .clk_i      (CLOCK_50),
      .rst_ni     (Resetn),
      .pressed_i  (!km_sync_q[1]),
      .suppress_i (v_accept),
      .accept_o   (m_accept),
      .pulse_o    (m_pulse),
      .state_o    (m_state)
   );

   // Snapshot the synchronized code on the same edge that raises a pulse.
   // A suppressed modify acceptance only coincides with a validate one, so
   // loading on either acceptance loads exactly when a pulse is emitted.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         d_out_q <= 4'b0000;
      end else if (v_accept || m_accept) begin
         d_out_q <= sw_s_q;
      end
   end

   assign d_out          = d_out_q;
   assign validate_pulse = v_pulse;
   assign modify_pulse   = m_pulse;
   assign busy           = (v_state != ST_RELEASED) || (m_state != ST_RELEASED);

endmodule

// File: tb/tb_key_entry_conditioner.sv
module tb_key_entry_conditioner;
   localparam int D = 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kv_n = 1'b1;
   logic       km_n = 1'b1;
   logic [3:0] sw = 4'b0000;
   logic [3:0] d_out;
   logic       vp;
   logic       mp;
   logic       busy;

   initial forever #5 clk = ~clk;

   key_entry_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .CLOCK_50       (clk),
      .Resetn         (rst_n),
      .KEY_validate_n (kv_n),
      .KEY_modify_n   (km_n),
      .SW             (sw),
      .d_out          (d_out),
      .validate_pulse (vp),
      .modify_pulse   (mp),
      .busy           (busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each button: the accepted level plus the length of the current run of
   // samples that disagree with it. A run of D+1 disagreeing samples flips
   // the accepted level; becoming pressed is an accepted press.
   logic       m_v_acc = 1'b0;
   logic       m_m_acc = 1'b0;
   int         m_v_run = 0;
   int         m_m_run = 0;
   logic [3:0] m_d = 4'b0000;
   logic       kv_pipe[$] = '{1'b1, 1'b1};
   logic       km_pipe[$] = '{1'b1, 1'b1};
   logic [3:0] sw_pipe[$] = '{4'b0000, 4'b0000};
   // expected {vp, mp, busy, d_out} for the next sampling point
   logic [6:0] exp_q[$];
   int         pcnt = 0;

   function automatic void step(input logic pressed, inout logic acc, inout int run,
                                output logic accept);
      accept = 1'b0;
      if (pressed != acc) begin
         run++;
         if (run == D + 1) begin
            acc    = pressed;
            run    = 0;
            accept = pressed;
         end
      end else begin
         run = 0;
      end
   endfunction

   task automatic model_reset();
      m_v_acc = 1'b0;
      m_m_acc = 1'b0;
      m_v_run = 0;
      m_m_run = 0;
      m_d     = 4'b0000;
      kv_pipe = '{1'b1, 1'b1};
      km_pipe = '{1'b1, 1'b1};
      sw_pipe = '{4'b0000, 4'b0000};
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         model_reset();
         if (!clk || $time == 0 || exp_q.size() > 0) exp_q.delete();
         exp_q.push_back(7'b0);
      end else begin
         logic       kv_s;
         logic       km_s;
         logic [3:0] sw_s;
         logic       va;
         logic       ma;
         logic       eb;
         pcnt++;
         kv_s = kv_pipe.pop_front();
         km_s = km_pipe.pop_front();
         sw_s = sw_pipe.pop_front();
         kv_pipe.push_back(kv_n);
         km_pipe.push_back(km_n);
         sw_pipe.push_back(sw);
         step(!kv_s, m_v_acc, m_v_run, va);
         step(!km_s, m_m_acc, m_m_run, ma);
         if (va || ma) m_d = sw_s;
         eb = m_v_acc || (m_v_run > 0) || m_m_acc || (m_m_run > 0);
         exp_q.push_back({va, ma && !va, eb, m_d});
      end
   end

   // ---------------- scoreboard / compare + monitor ----------------
   int         v_cnt = 0;
   int         m_cnt = 0;
   int         v_first = -1;
   int         m_first = -1;
   logic [3:0] d_at_v = 4'b0000;
   int         busy_last = -1;

   initial forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check("exp_q_underflow", 32'(exp_q.size()), 1);
      end else begin
         logic [6:0] e;
         e = exp_q.pop_front();
         check("validate_pulse", 32'(vp), 32'(e[6]));
         check("modify_pulse", 32'(mp), 32'(e[5]));
         check("busy", 32'(busy), 32'(e[4]));
         check("d_out", 32'(d_out), 32'(e[3:0]));
      end
      check("pulse_exclusive", 32'(vp && mp), 0);
      if (vp) begin
         v_cnt++;
         if (v_cnt == 1) begin
            v_first = pcnt;
            d_at_v  = d_out;
         end
      end
      if (mp) begin
         m_cnt++;
         if (m_cnt == 1) m_first = pcnt;
      end
      if (busy) busy_last = pcnt;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mark();
      pcnt      = 0;
      v_cnt     = 0;
      m_cnt     = 0;
      v_first   = -1;
      m_first   = -1;
      busy_last = -1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tick(3);
      @(negedge clk);
      check("rst_d_out", 32'(d_out), 0);
      check("rst_vp", 32'(vp), 0);
      check("rst_mp", 32'(mp), 0);
      check("rst_busy", 32'(busy), 0);
      tick(1);
      rst_n = 1'b1;
      tick(5);

      // Clean press
      sw = 4'b0110;
      kv_n = 1'b0;
      mark();
      tick(20);
      kv_n = 1'b1;
      tick(15);
      check("clean_v_count", 32'(v_cnt), 1);
      check("clean_v_latency", 32'(v_first), 7);
      check("clean_d_out", 32'(d_at_v), 6);
      check("clean_m_count", 32'(m_cnt), 0);

      // Bounce rejection on modify
      mark();
      for (int i = 0; i < 16; i++) begin
         km_n = ((i / 2) % 2) != 0;
         tick(1);
      end
      km_n = 1'b0;
      tick(10);
      km_n = 1'b1;
      tick(15);
      check("bounce_m_count", 32'(m_cnt), 1);
      check("bounce_m_cycle", 32'(m_first), 23);
      check("bounce_v_count", 32'(v_cnt), 0);

      // Long hold with a release glitch
      kv_n = 1'b0;
      mark();
      tick(100);
      kv_n = 1'b1;
      tick(2);
      kv_n = 1'b0;
      tick(1);
      kv_n = 1'b1;
      tick(20);
      check("hold_v_count", 32'(v_cnt), 1);
      check("hold_v_latency", 32'(v_first), 7);
      check("hold_busy_last", 32'(busy_last), 109);

      // Simultaneous press
      sw = 4'b1010;
      kv_n = 1'b0;
      km_n = 1'b0;
      mark();
      tick(20);
      kv_n = 1'b1;
      km_n = 1'b1;
      tick(20);
      check("simul_v_count", 32'(v_cnt), 1);
      check("simul_v_latency", 32'(v_first), 7);
      check("simul_d_out", 32'(d_at_v), 10);
      check("simul_m_count", 32'(m_cnt), 0);

      // Switch isolation
      sw = 4'b0011;
      kv_n = 1'b0;
      mark();
      tick(10);
      kv_n = 1'b1;
      tick(15);
      sw = 4'b1111;
      tick(10);
      @(negedge clk);
      check("iso_v_count", 32'(v_cnt), 1);
      check("iso_d_out_held", 32'(d_out), 3);
      tick(1);

      // Reset during PRESS_WAIT with the key held
      kv_n = 1'b0;
      mark();
      tick(4);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_d_out", 32'(d_out), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_vp", 32'(vp), 0);
      tick(3);
      rst_n = 1'b1;
      mark();
      tick(15);
      kv_n = 1'b1;
      tick(10);
      check("midrst_v_count", 32'(v_cnt), 1);
      check("midrst_v_latency", 32'(v_first), 7);

      // Randomized phase, checked cycle by cycle against the model
      for (int seg = 0; seg < 500; seg++) begin
         kv_n = $urandom_range(0, 1) != 0;
         km_n = $urandom_range(0, 2) != 0;
         sw   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 80) == 0) begin
            rst_n = 1'b0;
            tick($urandom_range(1, 3));
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) tick($urandom_range(5, 15));
         else tick($urandom_range(1, 4));
      end
      kv_n = 1'b1;
      km_n = 1'b1;
      tick(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
